if_id_stage: RTL and testbench

- IF/ID pipeline register of the 5-stage MIPS datapath.
- Captures the fetched instruction and PC+4, then splits the instruction into decode fields.
- Drives the 16-bit immediate and its extend-mode select (1 = sign, 0 = zero) straight into the downstream sign-extension stage.
- Handles stall hold, branch/jump flush bubbles, and a saturating stall-cycle counter for performance observation.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/instr_field_split.sv | 26 ++
 rtl/if_id_stage.sv | 105 ++++++++++
 tb/tb_if_id_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the immediate extend-mode decode.
package mips_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // Logical immediates zero-extend; everything else (bubbles included) sign-extends.
    function automatic logic sign_ext_sel(input logic [5:0] opcode);
        logic sel;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: sel = 1'b0;
            OP_RTYPE, OP_LUI:         sel = 1'b1;
            default:                  sel = 1'b1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a MIPS instruction word into decode fields and extend select.
// Zero latency; no flow control.
module instr_field_split
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm16,
    output logic               sign_ext
);

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm16    = instr[15:0];
    assign sign_ext = sign_ext_sel(instr[31:26]);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures instr/PC+4 and registers pre-split decode fields.
// Latency 1 Clk; stall holds all id_* state, flush (priority) loads a bubble; if_ready = ~stall.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   if_valid,
    input  logic [INSTR_W-1:0]     if_instr,
    input  logic [PC_W-1:0]        if_pc4,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   if_ready,
    output logic                   id_valid,
    output logic [INSTR_W-1:0]     id_instr,
    output logic [PC_W-1:0]        id_pc4,
    output logic [5:0]             id_opcode,
    output logic [4:0]             id_rs,
    output logic [4:0]             id_rt,
    output logic [4:0]             id_rd,
    output logic [4:0]             id_shamt,
    output logic [5:0]             id_funct,
    output logic [15:0]            id_imm16,
    output logic                   id_sign_ext,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [INSTR_W-1:0] nxt_instr;
    logic [PC_W-1:0]    nxt_pc4;
    logic [5:0]         nxt_opcode;
    logic [4:0]         nxt_rs;
    logic [4:0]         nxt_rt;
    logic [4:0]         nxt_rd;
    logic [4:0]         nxt_shamt;
    logic [5:0]         nxt_funct;
    logic [15:0]        nxt_imm16;
    logic               nxt_sign_ext;
    logic               load_en;

    // Flush and empty fetch both collapse to the NOP word, so the splitter sees one source.
    always_comb begin
        nxt_instr = NOP_INSTR;
        nxt_pc4   = '0;
        if (if_valid && !flush) begin
            nxt_instr = if_instr;
            nxt_pc4   = if_pc4;
        end
    end

    assign load_en  = flush || !stall;
    assign if_ready = ~stall;

    instr_field_split u_split (
        .instr    (nxt_instr),
        .opcode   (nxt_opcode),
        .rs       (nxt_rs),
        .rt       (nxt_rt),
        .rd       (nxt_rd),
        .shamt    (nxt_shamt),
        .funct    (nxt_funct),
        .imm16    (nxt_imm16),
        .sign_ext (nxt_sign_ext)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc4      <= '0;
            id_opcode   <= '0;
            id_rs       <= '0;
            id_rt       <= '0;
            id_rd       <= '0;
            id_shamt    <= '0;
            id_funct    <= '0;
            id_imm16    <= '0;
            id_sign_ext <= 1'b0;
        end else if (load_en) begin
            id_valid    <= if_valid && !flush;
            id_instr    <= nxt_instr;
            id_pc4      <= nxt_pc4;
            id_opcode   <= nxt_opcode;
            id_rs       <= nxt_rs;
            id_rt       <= nxt_rt;
            id_rd       <= nxt_rd;
            id_shamt    <= nxt_shamt;
            id_funct    <= nxt_funct;
            id_imm16    <= nxt_imm16;
            id_sign_ext <= nxt_sign_ext;
        end
    end

    // Counts only cycles where a live instruction is actually held back.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !flush && id_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        se;
        logic [3:0]  cnt;
        logic        rdy;
    } exp_t;

    logic        Clk;
    logic        Rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        stall;
    logic        flush;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
    logic        id_sign_ext;
    logic [3:0]  stall_cnt;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    if_id_stage #(.PC_W(32), .STALL_CNT_W(4)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc4      (if_pc4),
        .stall       (stall),
        .flush       (flush),
        .if_ready    (if_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_funct    (id_funct),
        .id_imm16    (id_imm16),
        .id_sign_ext (id_sign_ext),
        .stall_cnt   (stall_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".id_valid"},    32'(id_valid),    32'h0);
        chk({tag, ".id_instr"},    id_instr,         32'h0);
        chk({tag, ".id_pc4"},      id_pc4,           32'h0);
        chk({tag, ".id_opcode"},   32'(id_opcode),   32'h0);
        chk({tag, ".id_rt"},       32'(id_rt),       32'h0);
        chk({tag, ".id_imm16"},    32'(id_imm16),    32'h0);
        chk({tag, ".id_sign_ext"}, 32'(id_sign_ext), 32'h0);
        chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'h0);
    endtask

    // Monitor: one expected entry per clock edge issued by the driver.
    always @(posedge Clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            logic [31:0] ei;
            e  = q.pop_front();
            ei = e.instr;
            chk("id_valid",    32'(id_valid),    32'(e.v));
            chk("id_instr",    id_instr,         ei);
            chk("id_pc4",      id_pc4,           e.pc4);
            chk("id_opcode",   32'(id_opcode),   32'(ei[31:26]));
            chk("id_rs",       32'(id_rs),       32'(ei[25:21]));
            chk("id_rt",       32'(id_rt),       32'(ei[20:16]));
            chk("id_rd",       32'(id_rd),       32'(ei[15:11]));
            chk("id_shamt",    32'(id_shamt),    32'(ei[10:6]));
            chk("id_funct",    32'(id_funct),    32'(ei[5:0]));
            chk("id_imm16",    32'(id_imm16),    32'(ei[15:0]));
            chk("id_sign_ext", 32'(id_sign_ext), 32'(e.se));
            chk("stall_cnt",   32'(stall_cnt),   32'(e.cnt));
            chk("if_ready",    32'(if_ready),    32'(e.rdy));
        end
    end

    // Drive one edge's inputs and queue the hand-computed result of that edge.
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] pc,
                        input logic s, input logic f,
                        input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                        input logic ese, input logic [3:0] ecnt);
        exp_t e;
        @(negedge Clk);
        if_valid = v;
        if_instr = i;
        if_pc4   = pc;
        stall    = s;
        flush    = f;
        e.v = ev; e.instr = ei; e.pc4 = ep; e.se = ese; e.cnt = ecnt; e.rdy = ~s;
        q.push_back(e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc4 = '0; stall = 1'b0; flush = 1'b0;
        #2;
        chk_zero("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        // Basic loads and extend-mode decode
        step(1, 32'h2008FFFF, 32'h04, 0, 0,  1, 32'h2008FFFF, 32'h04, 1, 4'd0);
        step(1, 32'h3108FFFF, 32'h08, 0, 0,  1, 32'h3108FFFF, 32'h08, 0, 4'd0);
        step(1, 32'h3508FFFF, 32'h0C, 0, 0,  1, 32'h3508FFFF, 32'h0C, 0, 4'd0);
        step(1, 32'h8D09FFFC, 32'h10, 0, 0,  1, 32'h8D09FFFC, 32'h10, 1, 4'd0);
        step(1, 32'h012A4020, 32'h14, 0, 0,  1, 32'h012A4020, 32'h14, 1, 4'd0);
        // Stall holds while fetch side keeps changing
        step(1, 32'hDEADBEEF, 32'h18, 1, 0,  1, 32'h012A4020, 32'h14, 1, 4'd1);
        step(1, 32'h3108AAAA, 32'h1C, 1, 0,  1, 32'h012A4020, 32'h14, 1, 4'd2);
        step(1, 32'hCAFEF00D, 32'h20, 1, 0,  1, 32'h012A4020, 32'h14, 1, 4'd3);
        step(1, 32'h3C011234, 32'h18, 0, 0,  1, 32'h3C011234, 32'h18, 1, 4'd3);
        // Flush beats stall: bubble, counter untouched
        step(1, 32'h8D09FFFC, 32'h1C, 1, 1,  0, 32'h0,        32'h0,  1, 4'd3);
        step(0, 32'h3508FFFF, 32'h20, 0, 0,  0, 32'h0,        32'h0,  1, 4'd3);
        // Stall on a bubble does not count
        step(1, 32'h3508FFFF, 32'h20, 1, 0,  0, 32'h0,        32'h0,  1, 4'd3);
        step(1, 32'h39AB00FF, 32'h20, 0, 0,  1, 32'h39AB00FF, 32'h20, 0, 4'd3);
        // Long stall saturates the 4-bit counter
        for (int k = 0; k < 20; k++) begin
            logic [3:0] c;
            c = (k + 4 > 15) ? 4'hF : 4'(k + 4);
            step(1, 32'h11111111, 32'h24, 1, 0,  1, 32'h39AB00FF, 32'h20, 0, c);
        end
        // Asynchronous reset between edges during a stall
        step(1, 32'h22222222, 32'h28, 1, 0,  1, 32'h39AB00FF, 32'h20, 0, 4'hF);
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge Clk);
        Rst_n = 1'b1;
        step(1, 32'h2008FFFF, 32'h04, 0, 0,  1, 32'h2008FFFF, 32'h04, 1, 4'd0);
        step(0, 32'h0,        32'h0,  0, 0,  0, 32'h0,        32'h0,  1, 4'd0);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge Clk);
        #2;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
